sample_block_buffer: RTL and testbench
======================================

Name: sample_block_buffer

Overview:
- Ping-pong sample store between the raw 16-bit sample stream and FIR_FilterBank.
- Captures each block of BLOCK_SIZE samples while GenerateAutocorrelation, Durbinator and Quantizer compute that block's model.
- Replays the block on iStart, which is pulsed once the quantized coefficients are loaded.
- Replay drives iValid/iSample of FIR_FilterBank.

Parameters:
BLOCK_SIZE, 4096, samples per block (power of two)
SAMPLE_W, 16, sample width in bits (signed)
ADDR_W, 12, log2(BLOCK_SIZE)

Ports:
iClock  in  1  clock, rising-edge
iReset  in  1  asynchronous, active-low reset
iEnable  in  1  global advance; when low, no state changes on either side
iValid  in  1  iSample valid this cycle
iSample  in  SAMPLE_W  signed input sample
iStart  in  1  one-cycle pulse: replay oldest full bank
oSample  out  SAMPLE_W  replayed sample
oValid  out  1  oSample valid
oLast  out  1  high with final sample of a replayed block
oBlockReady  out  1  at least one full bank awaiting replay
oBusy  out  1  replay in progress (READ or DRAIN)
oOverflow  out  1  sticky: a sample was dropped because no bank was free

Behaviour:
- Reset (iReset=0, async): all outputs 0, both banks empty, write bank=0, write pointer=0, read FSM=IDLE, oOverflow cleared.
- Storage: two banks of BLOCK_SIZE x SAMPLE_W, synchronous-read RAM. Each bank has a full flag.
- Write side, on iEnable & iValid:
  - If the write bank is not full: store at the write pointer and increment.
  - When the pointer wraps from BLOCK_SIZE-1 to 0, set that bank full and toggle the write bank.
  - If the write bank is full (reader has not freed it): drop the sample, set oOverflow (remains set until reset), pointer unchanged.
- oBlockReady = OR of the full flags, registered; updates the cycle after the flag changes.
- Read FSM:
  - IDLE: on iEnable & iStart & (a bank is full), latch read bank = oldest full bank, read pointer=0, go to READ. iStart with no full bank is ignored.
  - READ: each iEnable cycle, issue a RAM read at the pointer and increment. After issuing address BLOCK_SIZE-1, go to DRAIN.
  - DRAIN: one cycle for the final data. Clear the read bank's full flag. Return to IDLE.
  - iStart while READ or DRAIN is ignored; it is not queued.
- Latency:
  - iStart in cycle t gives the first oValid in cycle t+2.
  - Output is BLOCK_SIZE consecutive oValid cycles while iEnable stays high.
  - oLast coincides with sample index BLOCK_SIZE-1.
  - oBusy is high from t+1 through the cycle carrying oLast.
- iEnable low freezes pointer, FSM and output registers. oValid holds its value but the consumer must also gate on iEnable. Replay is gap-free in enabled cycles.
- Bank order: blocks replay in write order. With both banks full, the bank written first is replayed first.
- Simultaneous events:
  - Write into bank A while bank B is replayed is legal.
  - A bank completes on the same edge its full flag is freed by DRAIN: the freed bank is writable next cycle; the completing bank becomes full. No sample is lost.
  - Write completing a bank in the same cycle as iStart in IDLE: iStart sees full flags from before the edge.
- Mid-operation reset: aborts replay, discards both banks, oValid drops immediately (async).
- Arithmetic: none on sample data; samples pass bit-exact.

Optional Feature:
- Macro: SAMPLE_BUFFER_PEAK_EN.
- Defined:
  - Adds output port oPeak (SAMPLE_W-1 bits, unsigned), the maximum |sample| of the block being replayed.
  - |-32768| saturates to 32767.
  - The peak is tracked per bank during write.
  - oPeak is valid from the first oValid of the replay and held until the next replay starts. Reset value 0.
- Not defined: no oPeak port and no peak logic. All other behaviour is identical.

Test Plan:
1. Write samples 0..4095 (iValid every cycle), pulse iStart → oValid from iStart+2 for 4096 cycles, oSample 0..4095 in order, oLast only on 4095, oBlockReady falls after DRAIN.
2. Ping-pong: write block A (value 100+i) and start its replay while writing block B (-i) concurrently → A replays exact, B captured intact, oOverflow=0, second iStart replays B.
3. Overflow: write 3×4096 samples with no iStart → oOverflow=1 at the first sample of block 3; replays return blocks 1 and 2 unchanged.
4. iEnable toggled 1-0-1 every cycle during replay → 4096 valid samples in enabled cycles, order preserved, no duplicates.
5. iStart with both banks empty → no oValid, oBusy stays 0. iStart during READ → ignored, block length still 4096.
6. Assert iReset=0 at sample 2000 of a replay → oValid/oBusy/oBlockReady=0 immediately; after release, a new full block replays correctly. With SAMPLE_BUFFER_PEAK_EN, a block containing -32768 gives oPeak=32767.

Source files
------------

// File: rtl/sample_block_buffer.sv
// sample_block_buffer: ping-pong sample store between the raw sample stream and FIR_FilterBank.
// Optional macro SAMPLE_BUFFER_PEAK_EN adds oPeak, the max |sample| of the block being replayed.
module sample_block_buffer #(
    parameter int BLOCK_SIZE = 4096,
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 12
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iEnable,
    input  logic                       iValid,
    input  logic signed [SAMPLE_W-1:0] iSample,
    input  logic                       iStart,
    output logic signed [SAMPLE_W-1:0] oSample,
    output logic                       oValid,
    output logic                       oLast,
    output logic                       oBlockReady,
    output logic                       oBusy,
`ifdef SAMPLE_BUFFER_PEAK_EN
    output logic [SAMPLE_W-2:0]        oPeak,
`endif
    output logic                       oOverflow
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_SIZE - 1);

    logic [SAMPLE_W-1:0] mem0 [BLOCK_SIZE];
    logic [SAMPLE_W-1:0] mem1 [BLOCK_SIZE];

    state_t              state, state_nx;
    logic [1:0]          full, full_nx;
    logic                wr_bank;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr, rd_ptr_nx;
    logic                rd_bank, rd_bank_nx;
    logic                wr_fire, wr_drop, wr_wrap;
    logic                rd_issue, rd_free;

    assign wr_fire = iEnable & iValid & ~full[wr_bank];
    assign wr_drop = iEnable & iValid & full[wr_bank];
    assign wr_wrap = wr_fire & (wr_ptr == LAST_ADDR);
    assign oBusy   = (state != IDLE);

    // With both banks full the write bank has wrapped back onto the older block.
    always_comb begin
        state_nx   = state;
        rd_ptr_nx  = rd_ptr;
        rd_bank_nx = rd_bank;
        rd_issue   = 1'b0;
        rd_free    = 1'b0;
        if (iEnable) begin
            unique case (state)
                IDLE: begin
                    if (iStart && (full != 2'b00)) begin
                        state_nx   = READ;
                        rd_ptr_nx  = '0;
                        rd_bank_nx = (full == 2'b11) ? wr_bank : full[1];
                    end
                end
                READ: begin
                    rd_issue  = 1'b1;
                    rd_ptr_nx = rd_ptr + 1'b1;
                    if (rd_ptr == LAST_ADDR) state_nx = DRAIN;
                end
                DRAIN: begin
                    rd_free  = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Freeing and completing always hit different banks, so both may apply on one edge.
    always_comb begin
        full_nx = full;
        if (rd_free) full_nx[rd_bank] = 1'b0;
        if (wr_wrap) full_nx[wr_bank] = 1'b1;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            oOverflow   <= 1'b0;
            oBlockReady <= 1'b0;
        end else if (iEnable) begin
            full        <= full_nx;
            oBlockReady <= |full;
            if (wr_fire) wr_ptr    <= wr_ptr + 1'b1;
            if (wr_wrap) wr_bank   <= ~wr_bank;
            if (wr_drop) oOverflow <= 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (wr_fire) begin
            if (wr_bank) mem1[wr_ptr] <= iSample;
            else         mem0[wr_ptr] <= iSample;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            oSample <= '0;
        end else if (rd_issue) begin
            oSample <= rd_bank ? mem1[rd_ptr] : mem0[rd_ptr];
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            rd_bank <= 1'b0;
            oValid  <= 1'b0;
            oLast   <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_ptr  <= rd_ptr_nx;
            rd_bank <= rd_bank_nx;
            if (iEnable) begin
                oValid <= rd_issue;
                oLast  <= rd_issue && (rd_ptr == LAST_ADDR);
            end
        end
    end

`ifdef SAMPLE_BUFFER_PEAK_EN
    logic [SAMPLE_W-2:0] peak0, peak1, in_mag;
    logic [SAMPLE_W-1:0] neg;

    // The most negative code has no positive twin and saturates to all ones.
    always_comb begin
        neg    = -iSample;
        in_mag = iSample[SAMPLE_W-1] ? (neg[SAMPLE_W-1] ? '1 : neg[SAMPLE_W-2:0])
                                     : iSample[SAMPLE_W-2:0];
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            peak0 <= '0;
            peak1 <= '0;
            oPeak <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_bank) peak1 <= ((wr_ptr == '0) || (in_mag > peak1)) ? in_mag : peak1;
                else         peak0 <= ((wr_ptr == '0) || (in_mag > peak0)) ? in_mag : peak0;
            end
            if (rd_issue && (rd_ptr == '0)) oPeak <= rd_bank ? peak1 : peak0;
        end
    end
`else
    // Peak tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_sample_block_buffer.sv
// Directed self-checking bench for sample_block_buffer (capture, ping-pong, overflow, enable gaps, reset).
module tb_sample_block_buffer;

    logic        clk = 1'b0;
    logic        rst_n, en, vld, start;
    logic [15:0] smp;
    logic [15:0] o_sample;
    logic        o_valid, o_last, o_block_ready, o_busy, o_overflow;
`ifdef SAMPLE_BUFFER_PEAK_EN
    logic [14:0] o_peak;
`endif

    int          n_checks, n_fail;
    logic [15:0] cap_q[$];
    int          last_pos[$];

    always #5 clk = ~clk;

    sample_block_buffer #(.BLOCK_SIZE(4096), .SAMPLE_W(16), .ADDR_W(12)) dut (
        .iClock     (clk),
        .iReset     (rst_n),
        .iEnable    (en),
        .iValid     (vld),
        .iSample    (smp),
        .iStart     (start),
        .oSample    (o_sample),
        .oValid     (o_valid),
        .oLast      (o_last),
        .oBlockReady(o_block_ready),
        .oBusy      (o_busy),
`ifdef SAMPLE_BUFFER_PEAK_EN
        .oPeak      (o_peak),
`endif
        .oOverflow  (o_overflow)
    );

    // The consumer takes a sample only in enabled cycles.
    always @(negedge clk) begin
        if (rst_n && en && o_valid) begin
            cap_q.push_back(o_sample);
            if (o_last) last_pos.push_back(cap_q.size() - 1);
        end
    end

    function automatic logic [15:0] gen(input int kind, input int i);
        logic [15:0] v;
        v = 16'(i);
        case (kind)
            0:       return v;
            1:       return 16'(100 + i);
            2:       return 16'(-i);
            3:       return 16'(3 * i + 1000);
            4:       return ~v;
            5:       return v ^ 16'h7777;
            6:       return 16'(i * 5) ^ 16'h5a5a;
            7:       return v + 16'h4000;
            8:       return (i == 17) ? 16'h8000 : (16'(i * 11) & 16'h3fff);
            default: return 16'h0000;
        endcase
    endfunction

`ifdef SAMPLE_BUFFER_PEAK_EN
    function automatic int peak_of(input int kind);
        int m, a;
        logic signed [15:0] s;
        m = 0;
        for (int i = 0; i < 4096; i++) begin
            s = gen(kind, i);
            a = (s < 0) ? -int'(s) : int'(s);
            if (a > 32767) a = 32767;
            if (a > m) m = a;
        end
        return m;
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_block(input int kind);
        for (int i = 0; i < 4096; i++) begin
            vld = 1'b1;
            smp = gen(kind, i);
            cycle();
        end
        vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit toggle, input int restart_at);
        int n;
        n = 0;
        while (o_busy && n < 20000) begin
            if (toggle) en = ~en;
            if (n == restart_at) start = 1'b1;
            cycle();
            start = 1'b0;
            n++;
        end
        en = 1'b1;
        check({tag, "_done"}, 32'(n < 20000), 1);
    endtask

    task automatic start_and_wait(input string tag, input int kind, input bit toggle, input int restart_at);
        cap_q.delete();
        last_pos.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        if (!toggle) begin
            check({tag, "_busy_t1"}, o_busy, 1);
            check({tag, "_valid_t1"}, o_valid, 0);
            cycle();
            check({tag, "_valid_t2"}, o_valid, 1);
            check({tag, "_first"}, o_sample, gen(kind, 0));
`ifdef SAMPLE_BUFFER_PEAK_EN
            check({tag, "_peak"}, o_peak, peak_of(kind));
`endif
        end
        wait_idle(tag, toggle, restart_at);
    endtask

    task automatic check_capture(input string tag, input int kind);
        int errs, lastpos;
        errs = 0;
        for (int i = 0; i < cap_q.size() && i < 4096; i++)
            if (cap_q[i] !== gen(kind, i)) errs++;
        lastpos = (last_pos.size() == 1) ? last_pos[0] : -1;
        check({tag, "_len"}, cap_q.size(), 4096);
        check({tag, "_data"}, errs, 0);
        check({tag, "_nlast"}, last_pos.size(), 1);
        check({tag, "_lastpos"}, lastpos, 4095);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1; en = 1'b0; vld = 1'b0; smp = '0; start = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) cycle();
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_block_ready, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_sample", o_sample, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        cycle();

        // iStart with both banks empty
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) begin
            check("t5_empty_busy", o_busy, 0);
            check("t5_empty_valid", o_valid, 0);
            cycle();
        end

        // single block replay
        write_block(0);
        check("t1_ready_lag", o_block_ready, 0);
        cycle();
        check("t1_ready", o_block_ready, 1);
        start_and_wait("t1", 0, 1'b0, -1);
        check_capture("t1", 0);
        check("t1_ready_hold", o_block_ready, 1);
        cycle();
        check("t1_ready_clr", o_block_ready, 0);

        // ping-pong: replay A while B is captured
        write_block(1);
        cap_q.delete();
        last_pos.delete();
        for (int i = 0; i < 4096; i++) begin
            vld   = 1'b1;
            smp   = gen(2, i);
            start = (i == 0);
            cycle();
        end
        start = 1'b0;
        vld   = 1'b0;
        wait_idle("t2a", 1'b0, -1);
        check_capture("t2a", 1);
        check("t2_ovf", o_overflow, 0);
        check("t2_ready_b", o_block_ready, 1);
        start_and_wait("t2b", 2, 1'b0, -1);
        check_capture("t2b", 2);

        // enable toggling during replay
        write_block(6);
        cycle();
        start_and_wait("t4", 6, 1'b1, -1);
        check_capture("t4", 6);

        // overflow, oldest-first order, iStart during READ ignored
        write_block(3);
        write_block(4);
        check("t3_ovf_pre", o_overflow, 0);
        vld = 1'b1;
        smp = gen(5, 0);
        cycle();
        check("t3_ovf_set", o_overflow, 1);
        for (int i = 1; i < 4096; i++) begin
            smp = gen(5, i);
            cycle();
        end
        vld = 1'b0;
        start_and_wait("t3a", 3, 1'b0, 100);
        check_capture("t3a", 3);
        cycle();
        check("t3_no_queue", o_busy, 0);
        check("t3_ready_2nd", o_block_ready, 1);
        start_and_wait("t3b", 4, 1'b0, -1);
        check_capture("t3b", 4);
        check("t3_ovf_sticky", o_overflow, 1);

        // reset mid-replay
        write_block(7);
        cap_q.delete();
        last_pos.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int n = 0; n < 5000 && cap_q.size() < 2000; n++) cycle();
        check("t6_reach", 32'(cap_q.size() >= 2000), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_ready", o_block_ready, 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        check("t6_ready_post", o_block_ready, 0);
        check("t6_ovf_post", o_overflow, 0);
        check("t6_busy_post", o_busy, 0);
        write_block(8);
        start_and_wait("t6b", 8, 1'b0, -1);
        check_capture("t6b", 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
